// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser back end.
package vend_pkg;

  localparam int ITEM_W     = 4;
  localparam int COIN_VALUE = 5;

  typedef enum logic [1:0] {
    IDLE,
    MOTOR,
    COIN,
    DONE
  } state_t;

  typedef struct packed {
    logic              change;
    logic [ITEM_W-1:0] item;
  } req_t;

  function automatic logic is_onehot(input logic [ITEM_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Request queue: synchronous FIFO with combinational read of the head entry.
module vend_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Vend actuator controller: queues requests, drives the item motor, then
// handshakes one change coin from the hopper.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int MOTOR_CYCLES   = 8,
  parameter int HOPPER_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              product_in,
  input  logic              change_in,
  input  logic [ITEM_W-1:0] item_no,
  input  logic              hopper_ack,
  output logic [ITEM_W-1:0] motor_en,
  output logic              hopper_req,
  output logic              vend_done,
  output logic              busy,
  output logic              overflow,
  output logic              bad_item,
  output logic              fault
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int MCW = $clog2(MOTOR_CYCLES + 1);
  localparam int TCW = $clog2(HOPPER_TIMEOUT + 1);

  state_t         state, state_d;
  req_t           wr_req, rd_req, cur_req, cur_d;
  logic [MCW-1:0] motor_cnt, motor_cnt_d;
  logic [TCW-1:0] to_cnt, to_cnt_d;
  logic           fault_set;

  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count, count_next;
  logic           item_ok, req_valid, pop, push_acc;

  assign item_ok   = is_onehot(item_no);
  assign req_valid = product_in && item_ok;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign push_acc  = req_valid && (!fifo_full || pop);
  assign wr_req    = '{change: change_in, item: item_no};

  vend_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .pop   (pop),
    .wdata (wr_req),
    .rdata (rd_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Queue occupancy after this edge, so busy can be registered without lag.
  always_comb begin
    count_next = fifo_count;
    if (push_acc && !pop)      count_next = fifo_count + 1'b1;
    else if (!push_acc && pop) count_next = fifo_count - 1'b1;
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state;
    motor_cnt_d = motor_cnt;
    to_cnt_d    = to_cnt;
    cur_d       = cur_req;
    fault_set   = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          cur_d       = rd_req;
          motor_cnt_d = MCW'(MOTOR_CYCLES);
          state_d     = MOTOR;
        end
      end
      MOTOR: begin
        motor_cnt_d = motor_cnt - 1'b1;
        if (motor_cnt == MCW'(1)) begin
          to_cnt_d = '0;
          state_d  = cur_req.change ? COIN : DONE;
        end
      end
      COIN: begin
        to_cnt_d = to_cnt + 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (hopper_ack) begin
          to_cnt_d = '0;
          state_d  = DONE;
        end else if (to_cnt_d == TCW'(HOPPER_TIMEOUT)) begin
          to_cnt_d  = '0;
          fault_set = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_req    <= '0;
      motor_cnt  <= '0;
      to_cnt     <= '0;
      motor_en   <= '0;
      hopper_req <= 1'b0;
      vend_done  <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bad_item   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      cur_req    <= cur_d;
      motor_cnt  <= motor_cnt_d;
      to_cnt     <= to_cnt_d;
      motor_en   <= (state_d == MOTOR) ? cur_d.item : '0;
      hopper_req <= (state_d == COIN);
      vend_done  <= (state_d == DONE);
      busy       <= (state_d != IDLE) || (count_next != '0);
      overflow   <= req_valid && fifo_full && !pop;
      bad_item   <= product_in && !item_ok;
      if (fault_set) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed self-checking bench for vend_dispenser with a request scoreboard.
module tb_vend_dispenser;
  import vend_pkg::*;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       product_in, change_in, hopper_ack;
  logic [3:0] item_no;
  logic [3:0] motor_en;
  logic       hopper_req, vend_done, busy, overflow, bad_item, fault;

  int   tests = 0;
  int   fails = 0;
  req_t exp_q[$];

  vend_dispenser #(
    .FIFO_DEPTH     (4),
    .MOTOR_CYCLES   (8),
    .HOPPER_TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .product_in (product_in),
    .change_in  (change_in),
    .item_no    (item_no),
    .hopper_ack (hopper_ack),
    .motor_en   (motor_en),
    .hopper_req (hopper_req),
    .vend_done  (vend_done),
    .busy       (busy),
    .overflow   (overflow),
    .bad_item   (bad_item),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single cycle and check the drop pulses after it.
  task automatic push_req(input logic [3:0] item, input logic chg,
                          input bit exp_ovf, input bit exp_bad);
    product_in = 1'b1;
    change_in  = chg;
    item_no    = item;
    step();
    product_in = 1'b0;
    change_in  = 1'b0;
    item_no    = 4'b0000;
    check("overflow", overflow, exp_ovf);
    check("bad_item", bad_item, exp_bad);
    if (!exp_ovf && !exp_bad) exp_q.push_back('{change: chg, item: item});
  endtask

  // Follow one vend from motor start to the cycle after vend_done.
  task automatic observe(input bit started, input int exp_motor, input int exp_wait,
                         input int ack_delay, input logic exp_fault);
    req_t e;
    int   n;
    n = 0;
    if (!started) begin
      while (motor_en == 4'b0000 && n < 50) begin
        step();
        n++;
      end
      check("motor_start_bound", n < 50, 1);
      if (exp_wait >= 0) check("idle_gap", n, exp_wait);
    end
    check("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("motor_item", motor_en, e.item);
    n = 0;
    while (motor_en == e.item && n < 100) begin
      check("no_hopper_in_motor", hopper_req, 0);
      step();
      n++;
    end
    check("motor_len", n, exp_motor);
    if (e.change) begin
      check("hopper_rise", hopper_req, 1);
      n = 0;
      while (hopper_req && n < 200) begin
        hopper_ack = (n == ack_delay);
        step();
        n++;
      end
      hopper_ack = 1'b0;
      check("hopper_len", n, (ack_delay >= 0) ? ack_delay + 1 : TIMEOUT);
    end
    check("done_pulse", vend_done, 1);
    check("hopper_low_at_done", hopper_req, 0);
    check("motor_low_at_done", motor_en, 0);
    check("fault", fault, exp_fault);
    step();
    check("done_single", vend_done, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("motor_onehot0", $onehot0(motor_en), 1);
      check("motor_hopper_excl", (motor_en != 4'b0000) && hopper_req, 0);
    end
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    product_in = 1'b0;
    change_in  = 1'b0;
    hopper_ack = 1'b0;
    item_no    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {motor_en, hopper_req, vend_done, busy, overflow, bad_item, fault}, 0);
    rst_n = 1'b1;
    step();

    // Plain vend, no change.
    push_req(4'b0010, 1'b0, 0, 0);
    check("busy_after_push", busy, 1);
    observe(0, 8, 1, -1, 1'b0);
    check("idle_not_busy", busy, 0);

    // Change owed, ack three cycles after the request rises.
    push_req(4'b1000, 1'b1, 0, 0);
    observe(0, 8, 1, 3, 1'b0);

    // Change owed, hopper never answers; the next vend still completes.
    push_req(4'b0001, 1'b1, 0, 0);
    observe(0, 8, 1, -1, 1'b1);
    push_req(4'b0100, 1'b0, 0, 0);
    observe(0, 8, 1, -1, 1'b1);

    // Invalid selects, change without product, stray ack: all ignored.
    push_req(4'b0000, 1'b0, 0, 1);
    check("bad0_busy", busy, 0);
    push_req(4'b0110, 1'b1, 0, 1);
    check("bad_pulse_single", bad_item, 1);
    change_in  = 1'b1;
    hopper_ack = 1'b1;
    step();
    change_in  = 1'b0;
    hopper_ack = 1'b0;
    check("bad_pulse_clear", bad_item, 0);
    for (int i = 0; i < 4; i++) begin
      check("ignored_motor", motor_en, 0);
      check("ignored_busy", busy, 0);
      check("ignored_done", vend_done, 0);
      step();
    end

    // Burst of five while the first vend is in MOTOR; the fifth overflows.
    push_req(4'b0001, 1'b0, 0, 0);
    step();
    check("burst_motor_on", motor_en, 4'b0001);
    push_req(4'b0010, 1'b0, 0, 0);
    push_req(4'b0100, 1'b1, 0, 0);
    push_req(4'b1000, 1'b0, 0, 0);
    push_req(4'b0001, 1'b0, 0, 0);
    push_req(4'b0010, 1'b0, 1, 0);
    step();
    check("overflow_single", overflow, 0);
    observe(1, 2, -1, -1, 1'b1);
    observe(0, 8, 1, -1, 1'b1);
    observe(0, 8, 1, 0, 1'b1);
    observe(0, 8, 1, -1, 1'b1);
    observe(0, 8, 1, -1, 1'b1);
    check("sb_drained", exp_q.size(), 0);
    check("burst_idle", busy, 0);

    // Reset in COIN with two requests queued.
    push_req(4'b0001, 1'b1, 0, 0);
    push_req(4'b0100, 1'b0, 0, 0);
    push_req(4'b1000, 1'b0, 0, 0);
    n = 0;
    while (!hopper_req && n < 50) begin
      step();
      n++;
    end
    check("coin_reached", hopper_req, 1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {motor_en, hopper_req, vend_done, busy, overflow, bad_item, fault}, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("post_rst_motor", motor_en, 0);
      check("post_rst_done", vend_done, 0);
      check("post_rst_busy", busy, 0);
    end
    check("post_rst_fault", fault, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
